ws2812b_frame_sequencer: RTL and testbench
==========================================

# ws2812b_frame_sequencer

Double-buffered frame controller that sequences the WS2812b serial driver for the Ambilight strip. Upstream logic fills a back buffer one LED at a time and requests a commit. The block swaps buffers only at the driver's frame boundary, so a frame is never torn mid-transmission. It also holds the driver in reset until the first frame exists.

## Interface
- NUM_LEDS, 150, LEDs in the chain; must match the driver instance.
- AW, log2(NUM_LEDS) (ceiling), LED address width; must match the driver's address width.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  upstream write strobe
- wr_ready  out  1  back buffer accepts writes
- wr_addr  in  AW  LED index to write
- wr_rgb  in  24  {red, green, blue}, 8 bits each
- commit  in  1  single-cycle request to display the back buffer
- commit_pending  out  1  commit accepted, swap not yet done
- frame_swap  out  1  one-cycle pulse when the buffers swap
- frame_count  out  16  number of swaps since reset; wraps
- brightness  in  8  global scale; present only with SEQ_BRIGHTNESS_EN
- drv_reset  out  1  active-high reset to the driver
- drv_address  in  AW  driver's current LED address
- drv_red, drv_green, drv_blue  out  8 each  colour for drv_address

## Operation
- Storage: two banks of NUM_LEDS x 24 bits. Register `front` selects the bank being displayed; the other bank is the back buffer.
- Write rule: a write occurs when wr_valid && wr_ready. It targets back[wr_addr]. If wr_addr >= NUM_LEDS, the write is accepted and discarded.
- FSM states:
  - IDLE (reset state):
    - drv_reset=1, wr_ready=1.
    - On commit: toggle `front`, pulse frame_swap, go to RUN.
  - RUN:
    - drv_reset=0, wr_ready=1.
    - On commit: set commit_pending=1 and go to SWAP_WAIT.
  - SWAP_WAIT:
    - wr_ready=0; the back buffer is locked.
    - On a frame boundary: toggle `front`, pulse frame_swap, clear commit_pending, return to RUN.
- Frame boundary: cycle where drv_address == 0 and the registered previous drv_address != 0 (driver wrapped after its last LED).
- Commit in SWAP_WAIT is ignored. Commit coinciding with a boundary in RUN is only registered; the swap waits for the next boundary.
- frame_count increments on every frame_swap, including the IDLE swap, and wraps from 0xFFFF to 0.
- Read path: drv_rgb is registered from front[drv_address]. If drv_address >= NUM_LEDS, output 0.
- Swap-and-read in the same cycle: the read uses the old `front`, and the new bank is visible from the next read. This is harmless because the driver latches its colour long after the address changes.

## Timing
- Reset values:
  - state=IDLE, front=0, drv_reset=1, wr_ready=1.
  - commit_pending=0, frame_swap=0, frame_count=0.
  - drv_red/green/blue=0, previous-address register=0.
- Bank contents are not reset; RAM inference is permitted.
- Write-to-storage latency: 1 cycle.
- Read latency from a drv_address change to drv_rgb: 1 cycle without the macro, 2 with it.
- IDLE commit: frame_swap in the cycle after commit; drv_reset falls in that same cycle.
- SWAP_WAIT: frame_swap is asserted in the cycle after the boundary is detected. wr_ready rises in the same cycle as frame_swap.
- Reset asserted mid-frame: everything returns to IDLE immediately, and drv_reset re-asserts asynchronously.

## Configuration
- SEQ_BRIGHTNESS_EN defined:
  - Adds the brightness port and a second pipeline stage.
  - Each channel output = (channel * (brightness + 1)) >> 8, using a 16-bit product and taking bits [15:8].
  - brightness=255 passes values through; brightness=0 gives channel >> 8, i.e. 0.
- SEQ_BRIGHTNESS_EN undefined: no brightness port, channels pass through unscaled, read latency is 1 cycle.

## Test plan
- Reset, then write LED 0 = 0x102030 and commit → drv_reset low next cycle, frame_swap=1, frame_count=1. With drv_address=0, drv_red=0x10, drv_green=0x20, drv_blue=0x30 after the read latency.
- In RUN, commit, then drive drv_address 5→149→0 → commit_pending and wr_ready=0 until the cycle after address 0 appears. Then frame_swap pulses, and outputs at address 0 show the newly written bank.
- In SWAP_WAIT, hold wr_valid with LED 3 = 0xFFFFFF → no write until wr_ready returns. The old bank's LED 3 value is unchanged.
- Write with wr_addr=200 (NUM_LEDS=150), and drive drv_address=200 → write is accepted without corrupting any LED; drv_rgb=0.
- Apply reset_n low mid-SWAP_WAIT → drv_reset=1 and commit_pending=0 immediately, frame_count=0, FSM in IDLE.
- With SEQ_BRIGHTNESS_EN, stored 0x80FF01: brightness=127 → outputs 0x40, 0x7F, 0x00; brightness=255 → 0x80, 0xFF, 0x01.

Source files
------------

// File: rtl/ws2812b_frame_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ws2812b_frame_sequencer_if                                     |
// | Brief    : Upstream write/commit and driver read signals for the frame    |
// |            sequencer. SEQ_BRIGHTNESS_EN adds the brightness input.        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ws2812b_frame_sequencer_if #(
  parameter int AW = 8
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_rgb;
  logic          commit;
  logic          commit_pending;
  logic          frame_swap;
  logic [15:0]   frame_count;
`ifdef SEQ_BRIGHTNESS_EN
  logic [7:0]    brightness;
`endif
  logic          drv_reset;
  logic [AW-1:0] drv_address;
  logic [7:0]    drv_red;
  logic [7:0]    drv_green;
  logic [7:0]    drv_blue;

`ifdef SEQ_BRIGHTNESS_EN
  modport slave (
    input  wr_valid, wr_addr, wr_rgb, commit, brightness, drv_address,
    output wr_ready, commit_pending, frame_swap, frame_count,
           drv_reset, drv_red, drv_green, drv_blue
  );
  modport master (
    output wr_valid, wr_addr, wr_rgb, commit, brightness, drv_address,
    input  wr_ready, commit_pending, frame_swap, frame_count,
           drv_reset, drv_red, drv_green, drv_blue
  );
`else
  modport slave (
    input  wr_valid, wr_addr, wr_rgb, commit, drv_address,
    output wr_ready, commit_pending, frame_swap, frame_count,
           drv_reset, drv_red, drv_green, drv_blue
  );
  modport master (
    output wr_valid, wr_addr, wr_rgb, commit, drv_address,
    input  wr_ready, commit_pending, frame_swap, frame_count,
           drv_reset, drv_red, drv_green, drv_blue
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ws2812b_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ws2812b_frame_sequencer                                        |
// | Brief    : Double-buffered WS2812b frame store; swaps banks only at the   |
// |            driver frame boundary. SEQ_BRIGHTNESS_EN adds global scaling.  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module ws2812b_frame_sequencer #(
  parameter int NUM_LEDS = 150,
  parameter int AW       = $clog2(NUM_LEDS)
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  ws2812b_frame_sequencer_if.slave bus
);

  localparam logic [AW:0] c_num_leds = (AW+1)'(NUM_LEDS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          front_q, front_d;
  logic          pending_q, pending_d;
  logic          swap_q, swap_d;
  logic [15:0]   count_q, count_d;
  logic [AW-1:0] prev_addr_q;

  logic [23:0]   bank0_q [NUM_LEDS];
  logic [23:0]   bank1_q [NUM_LEDS];

  logic          w_boundary;
  logic          w_wr_en;
  logic          w_rd_in_range;
  logic [23:0]   w_rd_data;
  logic [23:0]   rgb_q;

  assign w_boundary    = (bus.drv_address == '0) && (prev_addr_q != '0);
  assign w_wr_en       = bus.wr_valid && (state_q != ST_SWAP_WAIT) &&
                         ({1'b0, bus.wr_addr} < c_num_leds);
  assign w_rd_in_range = ({1'b0, bus.drv_address} < c_num_leds);

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    pending_d = pending_q;
    swap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.commit) begin
          state_d = ST_RUN;
          front_d = ~front_q;
          swap_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // A commit on a boundary cycle still waits for the following boundary.
        if (bus.commit) begin
          state_d   = ST_SWAP_WAIT;
          pending_d = 1'b1;
        end
      end
      ST_SWAP_WAIT: begin
        if (w_boundary) begin
          state_d   = ST_RUN;
          front_d   = ~front_q;
          swap_d    = 1'b1;
          pending_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    count_d = swap_d ? (count_q + 16'd1) : count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      front_q     <= 1'b0;
      pending_q   <= 1'b0;
      swap_q      <= 1'b0;
      count_q     <= 16'd0;
      prev_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      pending_q   <= pending_d;
      swap_q      <= swap_d;
      count_q     <= count_d;
      prev_addr_q <= bus.drv_address;
    end
  end

  // Bank storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (front_q) bank0_q[bus.wr_addr] <= bus.wr_rgb;
      else         bank1_q[bus.wr_addr] <= bus.wr_rgb;
    end
  end

  always_comb begin
    w_rd_data = 24'd0;
    if (w_rd_in_range) begin
      w_rd_data = front_q ? bank1_q[bus.drv_address] : bank0_q[bus.drv_address];
    end
  end

`ifdef SEQ_BRIGHTNESS_EN
  logic [23:0] raw_q;
  logic [8:0]  w_mult;

  assign w_mult = {1'b0, bus.brightness} + 9'd1;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] m);
    logic [15:0] p;
    p = {8'd0, c} * {7'd0, m};
    return p[15:8];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_q <= 24'd0;
      rgb_q <= 24'd0;
    end else begin
      raw_q <= w_rd_data;
      rgb_q <= {scale(raw_q[23:16], w_mult),
                scale(raw_q[15:8],  w_mult),
                scale(raw_q[7:0],   w_mult)};
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rgb_q <= 24'd0;
    else          rgb_q <= w_rd_data;
  end
`endif

  assign bus.wr_ready       = (state_q != ST_SWAP_WAIT);
  assign bus.drv_reset      = (state_q == ST_IDLE);
  assign bus.commit_pending = pending_q;
  assign bus.frame_swap     = swap_q;
  assign bus.frame_count    = count_q;
  assign bus.drv_red        = rgb_q[23:16];
  assign bus.drv_green      = rgb_q[15:8];
  assign bus.drv_blue       = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ws2812b_frame_sequencer                                     |
// | Brief    : Scoreboard bench with a frame-level reference model.           |
// |            Honours SEQ_BRIGHTNESS_EN when defined.                        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ws2812b_frame_sequencer;

  localparam int NUM_LEDS = 150;
  localparam int AW       = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ws2812b_frame_sequencer_if #(.AW(AW)) bus ();

  ws2812b_frame_sequencer #(.NUM_LEDS(NUM_LEDS), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          drv_reset;
    bit          wr_ready;
    bit          commit_pending;
    bit          frame_swap;
    int          count;
    bit          rgb_known;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what has been written where, which bank is shown,
  // whether the strip has started and whether a commit is waiting.
  logic [23:0] m_bank  [2][NUM_LEDS];
  bit          m_known [2][NUM_LEDS];
  bit          m_started, m_pending, m_front;
  int          m_count, m_prev;
  logic [23:0] m_raw;
  bit          m_raw_known;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] scale(logic [7:0] c, logic [7:0] b);
    int v;
    v = (int'(c) * (int'(b) + 1)) / 256;
    return v[7:0];
  endfunction

  task automatic model_reset();
    m_started = 0; m_pending = 0; m_front = 0;
    m_count = 0; m_prev = 0;
    m_raw = 24'd0; m_raw_known = 1;
  endtask

  task automatic model_edge();
    exp_t        e;
    int          a, wa;
    logic [23:0] rd;
    bit          rd_known, swap, boundary;
    a  = int'(bus.drv_address);
    wa = int'(bus.wr_addr);
    if (a < NUM_LEDS) begin
      rd = m_bank[m_front][a]; rd_known = m_known[m_front][a];
    end else begin
      rd = 24'd0; rd_known = 1;
    end
    if (bus.wr_valid && !m_pending && wa < NUM_LEDS) begin
      m_bank[!m_front][wa]  = bus.wr_rgb;
      m_known[!m_front][wa] = 1;
    end
    boundary = (a == 0) && (m_prev != 0);
    m_prev   = a;
    swap     = 0;
    if (!m_started && bus.commit) begin
      m_started = 1; swap = 1;
    end else if (m_started && !m_pending && bus.commit) begin
      m_pending = 1;
    end else if (m_pending && boundary) begin
      m_pending = 0; swap = 1;
    end
    if (swap) begin
      m_front = !m_front;
      m_count = (m_count + 1) % 65536;
    end
    e.drv_reset      = !m_started;
    e.wr_ready       = !m_pending;
    e.commit_pending = m_pending;
    e.frame_swap     = swap;
    e.count          = m_count;
`ifdef SEQ_BRIGHTNESS_EN
    e.rgb       = {scale(m_raw[23:16], bus.brightness), scale(m_raw[15:8], bus.brightness),
                   scale(m_raw[7:0], bus.brightness)};
    e.rgb_known = m_raw_known;
    m_raw       = rd;
    m_raw_known = rd_known;
`else
    e.rgb       = rd;
    e.rgb_known = rd_known;
`endif
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("drv_reset",      32'(bus.drv_reset),      32'(e.drv_reset));
      check("wr_ready",       32'(bus.wr_ready),       32'(e.wr_ready));
      check("commit_pending", 32'(bus.commit_pending), 32'(e.commit_pending));
      check("frame_swap",     32'(bus.frame_swap),     32'(e.frame_swap));
      check("frame_count",    32'(bus.frame_count),    32'(e.count));
      if (e.rgb_known)
        check("drv_rgb", 32'({bus.drv_red, bus.drv_green, bus.drv_blue}), 32'(e.rgb));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_rgb = '0;
    bus.commit = 0; bus.drv_address = '0;
`ifdef SEQ_BRIGHTNESS_EN
    bus.brightness = 8'd255;
`endif
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_drv_reset"},      32'(bus.drv_reset),      32'd1);
    check({tag, "_wr_ready"},       32'(bus.wr_ready),       32'd1);
    check({tag, "_commit_pending"}, 32'(bus.commit_pending), 32'd0);
    check({tag, "_frame_swap"},     32'(bus.frame_swap),     32'd0);
    check({tag, "_frame_count"},    32'(bus.frame_count),    32'd0);
    check({tag, "_rgb"}, 32'({bus.drv_red, bus.drv_green, bus.drv_blue}), 32'd0);
  endtask

  task automatic random_phase(int n);
    int ctr = 0;
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, 255))
                                                 : AW'($urandom_range(0, NUM_LEDS-1));
      bus.wr_rgb   = 24'($urandom);
      bus.commit   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 49) == 0) ctr = $urandom_range(0, 255);
      else ctr = (ctr >= NUM_LEDS-1) ? 0 : ctr + 1;
      bus.drv_address = AW'(ctr);
`ifdef SEQ_BRIGHTNESS_EN
      bus.brightness = 8'($urandom);
`endif
      tick();
    end
    bus.commit = 0;
  endtask

  initial begin
    model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < NUM_LEDS; i++) m_known[b][i] = 0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1;
    model_reset();

    // First frame: write LED 0 and commit out of IDLE.
    bus.wr_valid = 1; bus.wr_addr = 8'd0; bus.wr_rgb = 24'h102030;
    tick();
    bus.wr_valid = 0; bus.commit = 1;
    tick();
    bus.commit = 0;
    repeat (3) tick();

    // Fill the back bank, commit, then sweep the driver across a frame while
    // trying to write LED 3 into the locked back buffer.
    for (int i = 0; i < NUM_LEDS; i++) begin
      bus.wr_valid = 1; bus.wr_addr = AW'(i); bus.wr_rgb = 24'($urandom);
      tick();
    end
    bus.wr_valid = 0; bus.commit = 1; bus.drv_address = 8'd5;
    tick();
    bus.commit = 0;
    bus.wr_valid = 1; bus.wr_addr = 8'd3; bus.wr_rgb = 24'hFFFFFF;
    for (int a = 5; a < NUM_LEDS; a++) begin
      bus.drv_address = AW'(a);
      tick();
    end
    bus.drv_address = 8'd0;
    repeat (3) tick();
    bus.wr_valid = 0;
    bus.drv_address = 8'd3;
    repeat (2) tick();

    // Out-of-range write and read.
    bus.wr_valid = 1; bus.wr_addr = 8'd200; bus.wr_rgb = 24'hABCDEF;
    bus.drv_address = 8'd200;
    repeat (3) tick();
    bus.wr_valid = 0;

`ifdef SEQ_BRIGHTNESS_EN
    bus.wr_valid = 1; bus.wr_addr = 8'd9; bus.wr_rgb = 24'h80FF01; bus.commit = 0;
    tick();
    bus.wr_valid = 0; bus.commit = 1; bus.drv_address = 8'd4;
    tick();
    bus.commit = 0; bus.drv_address = 8'd0;
    repeat (2) tick();
    bus.drv_address = 8'd9; bus.brightness = 8'd127;
    repeat (3) tick();
    bus.brightness = 8'd255;
    repeat (3) tick();
`endif

    random_phase(3000);

    // Reset in the middle of SWAP_WAIT.
    bus.wr_valid = 0; bus.drv_address = 8'd7; bus.commit = 1;
    tick();
    bus.commit = 0;
    tick();
    check("pending_before_reset", 32'(bus.commit_pending), 32'd1);
    @(posedge clk);
    model_edge();
    #3;
    reset_n = 0;
    drive_idle();
    sb_q.delete();
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();

    repeat (5) tick();
    random_phase(800);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
